// File: rtl/riscv_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_arb_pkg
// Description : Shared types and constants for the RISC-V unified memory
//               arbiter: FSM state encoding, request-source encoding and the
//               width of the conflict performance counter.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_arb_pkg;

  localparam int CONFLICT_W = 16;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic [0:0] {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } arb_src_t;

endpackage
`default_nettype wire

// File: rtl/riscv_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_arbiter_if
// Description : Bundles the fetch port, the load/store port and the memory
//               macro port of the unified memory arbiter.
//   master : core fetch/LSU request side plus the memory read-data return
//   slave  : the arbiter itself
// Ports       : if_* fetch request/grant/response, d_* load/store
//               request/grant/response, mem_* single-port memory macro.
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import riscv_arb_pkg::*;

  // Fetch port
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  // Load/store port
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  // Memory macro port
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/riscv_mem_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module      : riscv_arb_pick
// Description : Two-way request picker for the unified memory arbiter.
//               Default build: fixed priority, data over fetch.
//               With RISCV_ARB_RR_EN defined: on a conflict the source that
//               did not win last time is chosen, so neither side starves.
// Ports       : i_if_req, i_d_req  - pending requests
//               i_last_winner      - source of the most recent grant
//               o_winner           - selected source (meaningful if o_valid)
//               o_valid            - at least one request is pending
// Macro       : RISCV_ARB_RR_EN
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_arb_pick
  import riscv_arb_pkg::*;
(
  input  logic     i_if_req,
  input  logic     i_d_req,
  input  arb_src_t i_last_winner,
  output arb_src_t o_winner,
  output logic     o_valid
);

  assign o_valid = i_if_req | i_d_req;

`ifdef RISCV_ARB_RR_EN
  always_comb begin
    o_winner = SRC_D;
    if (i_if_req && i_d_req) begin
      // Alternate on conflict: hand the grant to whoever lost last time.
      o_winner = (i_last_winner == SRC_D) ? SRC_IF : SRC_D;
    end else if (i_if_req) begin
      o_winner = SRC_IF;
    end
  end
`else
  // Fixed priority does not look at history.
  logic w_unused_last_winner;
  assign w_unused_last_winner = (i_last_winner == SRC_D);

  always_comb begin
    o_winner = SRC_D;
    if (i_if_req && !i_d_req) begin
      o_winner = SRC_IF;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_arbiter
// Description : Shares the single-port unified I/D memory between the fetch
//               path and the load/store path. One access is issued per
//               grant-eligible cycle; reads are tracked against a fixed
//               memory latency and the response is routed to the requester.
//               Stores complete in their grant cycle. Counts cycles in which
//               both sources competed for a grant (saturating).
// Parameters  : ADDR_W  - byte address width
//               DATA_W  - data width, multiple of 8
//               MEM_LAT - memory read latency in cycles, 1..4
// Ports       : clkbar       - clock, rising edge active
//               resetbar     - asynchronous active-low reset
//               bus          - fetch / load-store / memory signal bundle
//               conflict_cnt - saturating fetch/data conflict counter
// Macro       : RISCV_ARB_RR_EN - alternating arbitration instead of
//               fixed data-over-fetch priority
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_mem_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                  clkbar,
  input  logic                  resetbar,
  riscv_mem_arbiter_if.slave    bus,
  output logic [CONFLICT_W-1:0] conflict_cnt
);

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [2:0]            r_lat_cnt;
  logic [2:0]            w_lat_nxt;
  arb_src_t              r_owner;
  arb_src_t              w_owner_nxt;
  arb_src_t              w_last_winner;
  logic [CONFLICT_W-1:0] r_conflict_cnt;

  arb_src_t              w_winner;
  logic                  w_pick_valid;
  logic                  w_resp;
  logic                  w_elig;
  logic                  w_grant;
  logic                  w_win_d;
  logic                  w_store;
  logic                  w_read_grant;
  logic                  w_conflict;
  logic [ADDR_W-1:0]     w_mem_addr;
  logic [DATA_W-1:0]     w_mem_wdata;
  logic [DATA_W/8-1:0]   w_mem_be;

  riscv_arb_pick u_pick (
    .i_if_req      (bus.if_req),
    .i_d_req       (bus.d_req),
    .i_last_winner (w_last_winner),
    .o_winner      (w_winner),
    .o_valid       (w_pick_valid)
  );

  // The response cycle of an outstanding read doubles as a grant slot, which
  // is what lets MEM_LAT=1 reads stream back to back. Eligibility is also
  // gated by resetbar so no grant leaks out combinationally while in reset.
  assign w_resp       = (r_state == ARB_WAIT) && (r_lat_cnt == 3'd1);
  assign w_elig       = resetbar && ((r_state == ARB_IDLE) || w_resp);
  assign w_grant      = w_elig && w_pick_valid;
  assign w_win_d      = (w_winner == SRC_D);
  assign w_store      = w_grant && w_win_d && bus.d_we;
  assign w_read_grant = w_grant && !(w_win_d && bus.d_we);
  assign w_conflict   = w_elig && bus.if_req && bus.d_req;

  assign w_mem_addr  = w_grant ? (w_win_d ? bus.d_addr : bus.if_addr) : '0;
  assign w_mem_wdata = w_store ? bus.d_wdata : '0;
  assign w_mem_be    = w_store ? bus.d_be    : '0;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clkbar or negedge resetbar) begin
    if (!resetbar) begin
      r_state   <= ARB_IDLE;
      r_lat_cnt <= 3'd0;
      r_owner   <= SRC_IF;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_nxt;
      r_owner   <= w_owner_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_lat_nxt     = r_lat_cnt;
    w_owner_nxt   = r_owner;

    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = w_mem_addr;
    bus.mem_wdata = w_mem_wdata;
    bus.mem_be    = w_mem_be;
    bus.if_rvalid = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.if_rdata  = '0;
    bus.d_rdata   = '0;

    if (r_state == ARB_WAIT) begin
      w_lat_nxt = r_lat_cnt - 3'd1;
    end

    // Response: read data is passed straight through from the macro.
    if (w_resp) begin
      w_state_nxt = ARB_IDLE;
      if (r_owner == SRC_D) begin
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = bus.mem_rdata;
      end else begin
        bus.if_rvalid = 1'b1;
        bus.if_rdata  = bus.mem_rdata;
      end
    end

    if (w_grant) begin
      bus.mem_en = 1'b1;
      bus.mem_we = w_store;
      bus.d_gnt  = w_win_d;
      bus.if_gnt = !w_win_d;
    end

    // A read granted in the response cycle overrides the return to idle.
    if (w_read_grant) begin
      w_state_nxt = ARB_WAIT;
      w_lat_nxt   = LAT_INIT;
      w_owner_nxt = w_winner;
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration history
  // --------------------------------------------------------------------------
`ifdef RISCV_ARB_RR_EN
  arb_src_t r_last_winner;

  always_ff @(posedge clkbar or negedge resetbar) begin
    if (!resetbar) begin
      r_last_winner <= SRC_IF;
    end else if (w_grant) begin
      r_last_winner <= w_winner;
    end
  end

  assign w_last_winner = r_last_winner;
`else
  assign w_last_winner = SRC_IF;
`endif

  // --------------------------------------------------------------------------
  // Conflict performance counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clkbar or negedge resetbar) begin
    if (!resetbar) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != {CONFLICT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_riscv_mem_arbiter
// Description : Self-checking bench for riscv_mem_arbiter. Two arbiters are
//               built, MEM_LAT=1 (index 0) and MEM_LAT=3 (index 1), each with
//               its own memory model and read-response scoreboard. Expected
//               read data comes from a reference memory updated from the
//               store stimulus. Macro: RISCV_ARB_RR_EN selects the expected
//               arbitration order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_arbiter;
  import riscv_arb_pkg::*;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk      = 1'b0;
  logic resetbar = 1'b0;
  int   cyc      = 0;
  int   total    = 0;
  int   bad      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus, one slot per arbiter
  logic [1:0]       s_if_req, s_d_req, s_d_we;
  logic [1:0][31:0] s_if_addr, s_d_addr, s_d_wdata;
  logic [1:0][3:0]  s_d_be;

  // Observed outputs, one slot per arbiter
  logic [1:0]       o_if_gnt, o_d_gnt, o_mem_en, o_mem_we, o_if_rvalid, o_d_rvalid;
  logic [1:0][3:0]  o_mem_be;
  logic [1:0][31:0] o_mem_addr, o_mem_wdata, o_if_rdata, o_d_rdata;
  logic [1:0][15:0] o_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'h0;  // word at byte 0x40 starts zero-filled
    return 32'hC0DE_0000 ^ (i * 32'h0101_0101);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int LAT = (g == 0) ? 1 : 3;

    riscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    logic [15:0] cnt;
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [7:0]  rd_pipe [LAT];
    exp_t        q[$];

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .clkbar       (clk),
      .resetbar     (resetbar),
      .bus          (bus),
      .conflict_cnt (cnt)
    );

    assign bus.if_req  = s_if_req[g];
    assign bus.if_addr = s_if_addr[g];
    assign bus.d_req   = s_d_req[g];
    assign bus.d_we    = s_d_we[g];
    assign bus.d_addr  = s_d_addr[g];
    assign bus.d_wdata = s_d_wdata[g];
    assign bus.d_be    = s_d_be[g];

    assign o_if_gnt[g]    = bus.if_gnt;
    assign o_d_gnt[g]     = bus.d_gnt;
    assign o_mem_en[g]    = bus.mem_en;
    assign o_mem_we[g]    = bus.mem_we;
    assign o_mem_be[g]    = bus.mem_be;
    assign o_mem_addr[g]  = bus.mem_addr;
    assign o_mem_wdata[g] = bus.mem_wdata;
    assign o_if_rvalid[g] = bus.if_rvalid;
    assign o_d_rvalid[g]  = bus.d_rvalid;
    assign o_if_rdata[g]  = bus.if_rdata;
    assign o_d_rdata[g]   = bus.d_rdata;
    assign o_cnt[g]       = cnt;

    // Memory macro model: byte-enabled write, fixed-latency read pipeline.
    initial begin
      for (int i = 0; i < 256; i++) begin
        mem[i]     = init_word(i);
        ref_mem[i] = init_word(i);
      end
      for (int i = 0; i < LAT; i++) rd_pipe[i] = 8'd0;
    end

    always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
      for (int i = LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
      rd_pipe[0] = bus.mem_addr[9:2];
    end

    assign bus.mem_rdata = mem[rd_pipe[LAT-1]];

    // Scoreboard: push on grant, compare rvalid/rdata every cycle.
    always @(negedge clk) begin
      logic        exp_i, exp_d;
      logic [31:0] exp_data;
      exp_t        e;
      if (!resetbar) begin
        q.delete();
      end else begin
        exp_i = 1'b0; exp_d = 1'b0; exp_data = 32'h0;
        if (q.size() != 0 && q[0].due == cyc) begin
          exp_i    = !q[0].is_d;
          exp_d    = q[0].is_d;
          exp_data = q[0].data;
        end
        check_eq($sformatf("if_rvalid_lat%0d", LAT), bus.if_rvalid, exp_i);
        check_eq($sformatf("d_rvalid_lat%0d", LAT), bus.d_rvalid, exp_d);
        if (exp_i && bus.if_rvalid) check_eq($sformatf("if_rdata_lat%0d", LAT), bus.if_rdata, exp_data);
        if (exp_d && bus.d_rvalid)  check_eq($sformatf("d_rdata_lat%0d", LAT), bus.d_rdata, exp_data);
        if (q.size() != 0 && q[0].due <= cyc) void'(q.pop_front());

        if (bus.if_gnt) begin
          e.is_d = 1'b0; e.data = ref_mem[s_if_addr[g][9:2]]; e.due = cyc + LAT;
          q.push_back(e);
        end
        if (bus.d_gnt) begin
          if (s_d_we[g]) begin
            for (int b = 0; b < 4; b++)
              if (s_d_be[g][b]) ref_mem[s_d_addr[g][9:2]][8*b +: 8] = s_d_wdata[g][8*b +: 8];
          end else begin
            e.is_d = 1'b1; e.data = ref_mem[s_d_addr[g][9:2]]; e.due = cyc + LAT;
            q.push_back(e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if_req = '0; s_d_req = '0; s_d_we = '0;
    s_if_addr = '0; s_d_addr = '0; s_d_wdata = '0; s_d_be = '0;

    // ---- Reset state, fetch request held during reset (MEM_LAT=1) ----
    s_if_req[0] = 1'b1; s_if_addr[0] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_if_gnt",   o_if_gnt[0],   0);
    check_eq("rst_mem_en",   o_mem_en[0],   0);
    check_eq("rst_mem_we",   o_mem_we[0],   0);
    check_eq("rst_mem_addr", o_mem_addr[0], 0);
    check_eq("rst_if_rval",  o_if_rvalid[0], 0);
    check_eq("rst_if_rdata", o_if_rdata[0], 0);
    check_eq("rst_cnt",      o_cnt[0],      0);
    step(); resetbar = 1'b1;
    @(negedge clk);
    check_eq("first_if_gnt",  o_if_gnt[0],   1);
    check_eq("first_mem_en",  o_mem_en[0],   1);
    check_eq("first_mem_adr", o_mem_addr[0], 0);
    step(); s_if_req[0] = 1'b0;
    @(negedge clk);
    check_eq("first_if_rval", o_if_rvalid[0], 1);

    // ---- Conflict: data load vs fetch ----
    step();
    s_if_req[0] = 1'b1; s_if_addr[0] = 32'h4;
    s_d_req[0]  = 1'b1; s_d_we[0] = 1'b0; s_d_addr[0] = 32'h100;
    @(negedge clk);
    check_eq("cf1_d_gnt",  o_d_gnt[0],  1);
    check_eq("cf1_if_gnt", o_if_gnt[0], 0);
    step(); s_d_req[0] = 1'b0;
    @(negedge clk);
    check_eq("cf1_if_gnt2", o_if_gnt[0], 1);
    check_eq("cf1_cnt",     o_cnt[0],    1);
    step(); s_if_req[0] = 1'b0;

    // ---- Lone load (data wins), then conflict ----
    s_d_req[0] = 1'b1; s_d_addr[0] = 32'h104;
    @(negedge clk);
    check_eq("lone_d_gnt", o_d_gnt[0], 1);
    step();
    s_d_addr[0] = 32'h108; s_if_req[0] = 1'b1; s_if_addr[0] = 32'h8;
    @(negedge clk);
`ifdef RISCV_ARB_RR_EN
    check_eq("cf2_if_first", o_if_gnt[0], 1);
    check_eq("cf2_d_wait",   o_d_gnt[0],  0);
    step(); s_if_req[0] = 1'b0;
    @(negedge clk);
    check_eq("cf2_d_second", o_d_gnt[0], 1);
`else
    check_eq("cf2_d_first", o_d_gnt[0],  1);
    check_eq("cf2_if_wait", o_if_gnt[0], 0);
    step(); s_d_req[0] = 1'b0;
    @(negedge clk);
    check_eq("cf2_if_second", o_if_gnt[0], 1);
`endif
    check_eq("cf2_cnt", o_cnt[0], 2);
    step(); s_if_req[0] = 1'b0; s_d_req[0] = 1'b0;

    // ---- Partial store then load of the same word ----
    s_d_req[0] = 1'b1; s_d_we[0] = 1'b1; s_d_addr[0] = 32'h40;
    s_d_wdata[0] = 32'hDEAD_BEEF; s_d_be[0] = 4'b0011;
    @(negedge clk);
    check_eq("st_d_gnt",     o_d_gnt[0],     1);
    check_eq("st_mem_we",    o_mem_we[0],    1);
    check_eq("st_mem_be",    o_mem_be[0],    4'b0011);
    check_eq("st_mem_addr",  o_mem_addr[0],  32'h40);
    check_eq("st_mem_wdata", o_mem_wdata[0], 32'hDEAD_BEEF);
    step(); s_d_we[0] = 1'b0; s_d_be[0] = 4'b0000;
    @(negedge clk);
    check_eq("ld_d_gnt",  o_d_gnt[0],  1);
    check_eq("ld_mem_we", o_mem_we[0], 0);
    step(); s_d_req[0] = 1'b0;
    @(negedge clk);
    check_eq("ld_rvalid", o_d_rvalid[0], 1);
    check_eq("ld_beef",   o_d_rdata[0],  32'h0000_BEEF);

    // ---- Back-to-back fetches at MEM_LAT=1 ----
    for (int i = 0; i < 4; i++) begin
      step(); s_if_req[0] = 1'b1; s_if_addr[0] = 32'h80 + 32'(4 * i);
      @(negedge clk);
      check_eq($sformatf("b2b_if_gnt%0d", i), o_if_gnt[0], 1);
    end
    step(); s_if_req[0] = 1'b0;

    // ---- MEM_LAT=3: load, then a fetch waits for the response slot ----
    s_d_req[1] = 1'b1; s_d_we[1] = 1'b0; s_d_addr[1] = 32'h20;
    @(negedge clk);
    check_eq("l3_d_gnt", o_d_gnt[1], 1);
    step(); s_d_req[1] = 1'b0; s_if_req[1] = 1'b1; s_if_addr[1] = 32'hC;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      check_eq($sformatf("l3_no_gnt_t%0d", i), {o_if_gnt[1], o_d_gnt[1]}, 2'b00);
      check_eq($sformatf("l3_no_men_t%0d", i), o_mem_en[1], 0);
      step();
    end
    @(negedge clk);
    check_eq("l3_d_rvalid", o_d_rvalid[1], 1);
    check_eq("l3_if_gnt",   o_if_gnt[1],   1);
    check_eq("l3_cnt",      o_cnt[1],      0);
    step(); s_if_req[1] = 1'b0;
    repeat (4) step();

    // ---- Reset in the middle of an outstanding read ----
    s_if_req[1] = 1'b1; s_if_addr[1] = 32'h10;
    @(negedge clk);
    check_eq("mr_if_gnt", o_if_gnt[1], 1);
    step(); s_if_req[1] = 1'b0; resetbar = 1'b0;
    @(negedge clk);
    check_eq("mr_rvalid", o_if_rvalid[1], 0);
    check_eq("mr_mem_en", o_mem_en[1],    0);
    check_eq("mr_cnt0",   o_cnt[0],       0);
    step(); resetbar = 1'b1; s_d_req[1] = 1'b1; s_d_addr[1] = 32'h24;
    @(negedge clk);
    check_eq("mr_post_gnt", o_d_gnt[1], 1);
    step(); s_d_req[1] = 1'b0;
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
